ad_src_ctrl: RTL

AD_SRC_CTRL -- requirements
Module: ad_src_ctrl

---
 rtl/ad_pkg.sv | 15 +
 rtl/ad_frm_cnt.sv | 50 +++++
 rtl/ad_src_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/ad_pkg.sv
// Shared types and defaults for the ADC source controller.
// Holds the FSM state encoding, data-width and blanking defaults.
package ad_pkg;

   localparam int unsigned AD_DW        = 24;
   localparam int unsigned AD_BLANK_CYC = 16;
   localparam int unsigned FRM_W        = 16;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_EOF = 2'd1,
      ST_BLANK    = 2'd2
   } ad_state_e;

endpackage

// File: rtl/ad_frm_cnt.sv
// Frame sample counter: flags first (sof) and last (eof) sample of a frame.
// Ports: clk_sys, rst_n, clr_i (sync clear), vld_i, frm_len_i -> sof_o, eof_o.
module ad_frm_cnt
   import ad_pkg::*;
(
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             vld_i,
   input  logic [FRM_W-1:0] frm_len_i,
   output logic             sof_o,
   output logic             eof_o
);

   logic [FRM_W-1:0] cnt_q, cnt_d;
   logic [FRM_W-1:0] len_q, len_d;
   logic [FRM_W-1:0] cfg_len;
   logic [FRM_W-1:0] len_cur;

   // Length 0 behaves as 1 (every sample is both sof and eof).
   assign cfg_len = (frm_len_i == '0) ? FRM_W'(1) : frm_len_i;

   // A new length is only picked up at the frame boundary.
   assign len_cur = (cnt_q == '0) ? cfg_len : len_q;

   assign sof_o = vld_i && (cnt_q == '0);
   assign eof_o = vld_i && (cnt_q == len_cur - FRM_W'(1));

   always_comb begin
      cnt_d = cnt_q;
      len_d = len_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (vld_i) begin
         if (cnt_q == '0) len_d = cfg_len;
         cnt_d = eof_o ? '0 : cnt_q + FRM_W'(1);
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         len_q <= FRM_W'(1);
      end else begin
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

endmodule

// File: rtl/ad_src_ctrl.sv
// Glitch-free switch between real ADC and test-pattern sample streams,
// switching only at frame end and inserting a blanking gap.
// Ports: clk_sys, rst_n, cfg_ad_tp, cfg_frm_len, tp_*/real_* inputs,
//        ad_data/ad_vld/ad_sof, tp_en, sel_tp, sw_busy, sw_done outputs.
module ad_src_ctrl
   import ad_pkg::*;
#(
   parameter int unsigned DW        = AD_DW,
   parameter int unsigned BLANK_CYC = AD_BLANK_CYC
) (
   input  logic          clk_sys,
   input  logic          rst_n,
   input  logic [7:0]    cfg_ad_tp,
   input  logic [15:0]   cfg_frm_len,
   input  logic [DW-1:0] tp_data,
   input  logic          tp_vld,
   input  logic [DW-1:0] real_data,
   input  logic          real_vld,
   output logic [DW-1:0] ad_data,
   output logic          ad_vld,
   output logic          ad_sof,
   output logic          tp_en,
   output logic          sel_tp,
   output logic          sw_busy,
   output logic          sw_done
);

   localparam int unsigned BW = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

   ad_state_e     state_q;
   logic [BW-1:0] blank_q;
   logic          sel_tp_q;
   logic          sw_done_q;
   logic [DW-1:0] ad_data_q;
   logic          ad_vld_q;
   logic          ad_sof_q;

   logic          target;
   logic [DW-1:0] src_data;
   logic          src_vld;
   logic          pass;
   logic          blank_end;
   logic          sof;
   logic          eof;

   assign target   = (cfg_ad_tp != 8'd0);
   assign src_data = sel_tp_q ? tp_data : real_data;
   assign src_vld  = sel_tp_q ? tp_vld  : real_vld;

   // Samples are dropped for the whole blanking window.
   assign pass      = src_vld && (state_q != ST_BLANK);
   assign blank_end = (state_q == ST_BLANK) && (blank_q == BLANK_LAST);

   ad_frm_cnt u_frm_cnt (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .clr_i     (blank_end),
      .vld_i     (pass),
      .frm_len_i (cfg_frm_len),
      .sof_o     (sof),
      .eof_o     (eof)
   );

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         blank_q   <= '0;
         sel_tp_q  <= 1'b0;
         sw_done_q <= 1'b0;
         ad_data_q <= '0;
         ad_vld_q  <= 1'b0;
         ad_sof_q  <= 1'b0;
      end else begin
         sw_done_q <= 1'b0;
         ad_data_q <= src_data;
         ad_vld_q  <= pass;
         ad_sof_q  <= sof;
         unique case (state_q)
            ST_RUN: begin
               if (target != sel_tp_q) state_q <= ST_WAIT_EOF;
            end
            ST_WAIT_EOF: begin
               // A reverted request wins over a coincident eof.
               if (target == sel_tp_q) begin
                  state_q <= ST_RUN;
               end else if (eof) begin
                  state_q <= ST_BLANK;
                  blank_q <= '0;
               end
            end
            ST_BLANK: begin
               blank_q <= blank_q + BW'(1);
               if (blank_end) begin
                  sel_tp_q  <= target;
                  sw_done_q <= 1'b1;
                  state_q   <= ST_RUN;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   // Generator is started early on a switch to test pattern and
   // stopped as soon as blanking begins on a switch back to real.
   assign tp_en   = (state_q == ST_BLANK) ? target : sel_tp_q;
   assign sw_busy = (state_q != ST_RUN);

   assign sel_tp  = sel_tp_q;
   assign sw_done = sw_done_q;
   assign ad_data = ad_data_q;
   assign ad_vld  = ad_vld_q;
   assign ad_sof  = ad_sof_q;

endmodule
